// File: rtl/cpu_ctrl_pkg.sv
// Run-control state encodings and divider helper shared by the CPU front panel logic.
// Pure declarations: no latency, no flow control.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } run_state_t;

   // Returns the terminal count (period - 1) for the selected run rate.
   function automatic logic [31:0] div_last(
      input logic [1:0]  hz,
      input logic [31:0] d0,
      input logic [31:0] d1,
      input logic [31:0] d2,
      input logic [31:0] d3
   );
      logic [31:0] d;
      case (hz)
         2'b00:   d = d0;
         2'b01:   d = d1;
         2'b10:   d = d2;
         default: d = d3;
      endcase
      return d - 32'd1;
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability debounce, rising-edge one-cycle pulse.
// Pulse appears 2 + DEB_CYCLES cycles after a clean press; no backpressure.
module btn_debounce #(
   parameter int unsigned DEB_CYCLES = 100000
) (
   input  logic clk,
   input  logic clr,
   input  logic btn,
   output logic pulse
);

   localparam int unsigned   CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;
   logic          settle;

   // The new level is accepted on the DEB_CYCLES-th consecutive differing sample.
   assign settle = (sync2 != level) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (clr) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         pulse <= settle && sync2;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (settle) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: free-run at a selectable tick rate, single-step, halt and resume.
// cpu_en is valid in the tick cycle (RUN) or the cycle after a button pulse; no backpressure.
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DIV0       = 10000,
   parameter int unsigned DIV1       = 100000,
   parameter int unsigned DIV2       = 1000000,
   parameter int unsigned DIV3       = 10000000,
   parameter int unsigned DEB_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [1:0]  Hz,
   input  logic        step_mode,
   input  logic        go_btn,
   input  logic        step_btn,
   input  logic        cpu_halt,
   output logic        cpu_en,
   output logic [1:0]  run_state,
   output logic [31:0] en_count
);

   logic        go_p;
   logic        step_p;
   logic [1:0]  hz_q;
   logic [31:0] div_last_q;
   logic [31:0] div_cnt;
   logic        hz_chg;
   logic        tick;
   logic        run_en;
   logic        pend_q;
   logic        pend_d;
   run_state_t  state_q;
   run_state_t  state_d;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_go_deb (
      .clk   (clk),
      .clr   (clr),
      .btn   (go_btn),
      .pulse (go_p)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
      .clk   (clk),
      .clr   (clr),
      .btn   (step_btn),
      .pulse (step_p)
   );

   // Terminal count is registered so the tick path is a plain 32-bit equality.
   always_ff @(posedge clk) begin
      hz_q       <= Hz;
      div_last_q <= div_last(Hz, 32'(DIV0), 32'(DIV1), 32'(DIV2), 32'(DIV3));
   end

   // A rate change restarts the period; the stale terminal count is never used.
   assign hz_chg = (Hz != hz_q);
   assign tick   = (state_q == ST_RUN) && !hz_chg && (div_cnt == div_last_q);

   always_comb begin
      state_d = state_q;
      pend_d  = 1'b0;
      run_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (go_p) state_d = step_mode ? ST_STEP : ST_RUN;
         end
         ST_RUN: begin
            run_en = tick && !cpu_halt;
            if (tick && cpu_halt) state_d = ST_HALT;
            else if (step_mode)   state_d = ST_STEP;
         end
         ST_STEP: begin
            if (!step_mode) begin
               state_d = ST_RUN;
            end else if (step_p) begin
               if (cpu_halt) state_d = ST_HALT;
               else          pend_d  = 1'b1;
            end
         end
         ST_HALT: begin
            if (go_p) begin
               pend_d  = 1'b1;
               state_d = step_mode ? ST_STEP : ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cpu_en    = !clr && (pend_q || run_en);
   assign run_state = state_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= ST_IDLE;
         pend_q   <= 1'b0;
         en_count <= '0;
         div_cnt  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         if (cpu_en) en_count <= en_count + 32'd1;
         if ((state_q != ST_RUN) || hz_chg || tick) div_cnt <= '0;
         else                                      div_cnt <= div_cnt + 32'd1;
      end
   end

endmodule
